elapsed_time_counter: RTL and testbench
=======================================

// Module: elapsed_time_counter
// PURPOSE
//  Parametrised run/pause elapsed-time counter for the activity tracker. A prescaler divides CLK down to a
//  TICK_HZ tick that increments ELAPSED, with parallel minutes/seconds fields for display. Adds pause without
//  losing sub-tick phase, lap capture, threshold event and wrap/saturate overflow modes. Feeds display and
//  step-rate logic.
// PARAMETERS
//  CLK_HZ     100_000_000  input clock frequency; CLK_HZ % TICK_HZ == 0 required
//  TICK_HZ    1            count rate; DIV = CLK_HZ/TICK_HZ, DIV >= 2 (elaboration error otherwise)
//  SEC_WIDTH  8            width of ELAPSED, >= 6; MIN_WIDTH = SEC_WIDTH-5 (localparam)
//  SATURATE   0            0: wrap at 2^SEC_WIDTH-1 -> 0; 1: hold at 2^SEC_WIDTH-1
// PORTS
//  CLK         in   1          system clock; single clock domain
//  RESET       in   1          synchronous, active-high reset
//  CLEAR       in   1          synchronous clear of counts, prescaler, OVERFLOW, LAP_* (not a mode change)
//  RUN         in   1          1: count; 0: pause, all state held (prescaler phase kept)
//  LAP         in   1          1-cycle pulse: capture current ELAPSED
//  THRESHOLD   in   SEC_WIDTH  compare value for THRESH_HIT; 0 disables
//  ELAPSED     out  SEC_WIDTH  ticks since last RESET/CLEAR
//  SECONDS     out  6          ELAPSED mod 60, range 0..59
//  MINUTES     out  MIN_WIDTH  ELAPSED div 60
//  TICK        out  1          1-cycle pulse in the cycle ELAPSED takes a new value
//  LAP_VALUE   out  SEC_WIDTH  last captured ELAPSED
//  LAP_VALID   out  1          1-cycle pulse the cycle LAP_VALUE updates
//  THRESH_HIT  out  1          1-cycle pulse when ELAPSED becomes == THRESHOLD via increment
//  OVERFLOW    out  1          sticky: set on first wrap/saturation, cleared by RESET/CLEAR
// BEHAVIOUR
//  Reset: all outputs and prescaler 0 the cycle after RESET sampled high. Priority RESET > CLEAR > LAP/count.
//  Prescaler: counts 0..DIV-1 only while RUN=1 and not clearing; RUN=0 freezes it (no reset, unlike gating).
//  Tick event: RUN=1 and prescaler==DIV-1 -> prescaler<=0; next cycle ELAPSED/SECONDS/MINUTES updated and
//   TICK=1 (registered). First tick DIV cycles after RUN rises from a cleared state.
//  Increment: SECONDS 59 -> 0 with MINUTES+1; ELAPSED+1. Invariant MINUTES*60+SECONDS == ELAPSED at all times.
//  Max (ELAPSED == 2^SEC_WIDTH-1) at tick: SATURATE=0 -> ELAPSED, SECONDS, MINUTES all <=0, TICK=1, OVERFLOW<=1;
//   SATURATE=1 -> all held, TICK=0, OVERFLOW<=1, THRESH_HIT not re-fired; prescaler keeps running.
//  LAP: LAP_VALUE <= ELAPSED as seen in the LAP cycle (pre-increment if tick coincides); LAP_VALID=1 next
//   cycle. LAP honoured when RUN=0. LAP with CLEAR or RESET ignored (LAP_VALUE 0, LAP_VALID 0).
//  THRESH_HIT: registered with TICK, when new ELAPSED == THRESHOLD != 0. Not fired by CLEAR/RESET, nor by
//   THRESHOLD changing onto the current value. Re-fires after wrap or CLEAR when reached again.
//  CLEAR mid-count: counts, prescaler, OVERFLOW, LAP_* to 0 next cycle; pending tick discarded; RUN honoured
//   again the following cycle.
//  All outputs registered; no combinational input->output paths.
// STRUCTURE
//  Package elapsed_time_pkg: SECONDS_PER_MIN=60, SEC_FIELD_W=6, function min_width(sec_width).
//  Sub-module tick_prescaler #(DIV): CLK, RESET, CLEAR, EN -> TICK_EN pulse (phase held when EN=0);
//   reusable by other rate blocks. Top holds counters, lap register, compare and overflow logic.
// TESTING  (bench params CLK_HZ=10, TICK_HZ=1 -> DIV=10, SEC_WIDTH=7, unless noted)
//  RUN=1 from clear, 650 cycles -> TICK every 10 cycles, first at cycle 10; ELAPSED=65, MINUTES=1, SECONDS=5.
//  RUN=1 for 34 cycles, RUN=0 for 50, RUN=1 for 6 -> ELAPSED 3 during pause, reaches 4 exactly at resume+6.
//  SATURATE=0, run to 127 then one more tick -> ELAPSED=0, SECONDS=0, MINUTES=0, OVERFLOW=1, TICK=1;
//   SATURATE=1 -> ELAPSED stays 127, no TICK, OVERFLOW=1.
//  THRESHOLD=5 -> THRESH_HIT once at 4->5; CLEAR then rerun -> fires again at 5; THRESHOLD=0 -> never.
//  LAP in the tick cycle of 8->9 -> LAP_VALUE=8, LAP_VALID one cycle later; LAP with CLEAR -> LAP_VALID=0.
//  RESET and CLEAR asserted mid-count (prescaler=7, ELAPSED=20) -> all outputs 0 next cycle; invariant
//   MINUTES*60+SECONDS==ELAPSED checked every cycle by assertion.

Source files
------------

// File: rtl/elapsed_time_pkg.sv
// Shared constants and helpers for the elapsed-time counter and its display fields.
package elapsed_time_pkg;

  localparam int SECONDS_PER_MIN = 60;
  localparam int SEC_FIELD_W     = 6;

  // Widest minutes value is (2^w - 1) / 60, which always fits in w-5 bits.
  function automatic int min_width(input int sec_width);
    return sec_width - 5;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock by DIV into a one-cycle tick enable; phase is frozen, not lost, while i_en is low.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick_en
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);
  // A tick coinciding with reset/clear is discarded.
  assign o_tick_en = i_en && w_at_last && !i_reset && !i_clear;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/elapsed_time_counter.sv
// Run/pause elapsed-time counter with minutes/seconds split, lap capture, threshold pulse and overflow.
module elapsed_time_counter
  import elapsed_time_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1,
  parameter int SEC_WIDTH = 8,
  parameter int SATURATE  = 0
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_clear,
  input  logic                            i_run,
  input  logic                            i_lap,
  input  logic [SEC_WIDTH-1:0]            i_threshold,
  output logic [SEC_WIDTH-1:0]            o_elapsed,
  output logic [SEC_FIELD_W-1:0]          o_seconds,
  output logic [min_width(SEC_WIDTH)-1:0] o_minutes,
  output logic                            o_tick,
  output logic [SEC_WIDTH-1:0]            o_lap_value,
  output logic                            o_lap_valid,
  output logic                            o_thresh_hit,
  output logic                            o_overflow
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int MIN_W = min_width(SEC_WIDTH);
  localparam logic [SEC_WIDTH-1:0]   MAX_E    = {SEC_WIDTH{1'b1}};
  localparam logic [SEC_FIELD_W-1:0] LAST_SEC = SEC_FIELD_W'(SECONDS_PER_MIN - 1);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("elapsed_time_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (SEC_WIDTH < 6) begin : g_bad_width
    $error("elapsed_time_counter: SEC_WIDTH must be >= 6");
  end

  logic [SEC_WIDTH-1:0]   r_elapsed;
  logic [SEC_FIELD_W-1:0] r_seconds;
  logic [MIN_W-1:0]       r_minutes;
  logic                   r_tick;
  logic [SEC_WIDTH-1:0]   r_lap_value;
  logic                   r_lap_valid;
  logic                   r_thresh_hit;
  logic                   r_overflow;

  logic                   w_tick_en;
  logic                   w_at_max;
  logic [SEC_WIDTH-1:0]   w_next_elapsed;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (i_clear),
    .i_en      (i_run),
    .o_tick_en (w_tick_en)
  );

  assign w_at_max       = (r_elapsed == MAX_E);
  assign w_next_elapsed = r_elapsed + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_elapsed    <= '0;
      r_seconds    <= '0;
      r_minutes    <= '0;
      r_tick       <= 1'b0;
      r_lap_value  <= '0;
      r_lap_valid  <= 1'b0;
      r_thresh_hit <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_tick       <= 1'b0;
      r_thresh_hit <= 1'b0;
      r_lap_valid  <= i_lap;
      if (i_lap) begin
        r_lap_value <= r_elapsed;
      end
      if (w_tick_en) begin
        if (w_at_max) begin
          r_overflow <= 1'b1;
          // Wrapping lands on 0, which can never match an enabled threshold.
          if (SATURATE == 0) begin
            r_elapsed <= '0;
            r_seconds <= '0;
            r_minutes <= '0;
            r_tick    <= 1'b1;
          end
        end else begin
          r_elapsed    <= w_next_elapsed;
          r_tick       <= 1'b1;
          r_thresh_hit <= (i_threshold != '0) && (w_next_elapsed == i_threshold);
          if (r_seconds == LAST_SEC) begin
            r_seconds <= '0;
            r_minutes <= r_minutes + 1'b1;
          end else begin
            r_seconds <= r_seconds + 1'b1;
          end
        end
      end
    end
  end

  assign o_elapsed    = r_elapsed;
  assign o_seconds    = r_seconds;
  assign o_minutes    = r_minutes;
  assign o_tick       = r_tick;
  assign o_lap_value  = r_lap_value;
  assign o_lap_valid  = r_lap_valid;
  assign o_thresh_hit = r_thresh_hit;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_elapsed_time_counter.sv
// Bench for elapsed_time_counter: wrap and saturate instances share stimulus, checked against a tick-count model.
module tb_elapsed_time_counter;

  localparam int CLK_HZ = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int SW = 7;
  localparam int MAXP1 = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          d_reset = 1'b0, d_clear = 1'b0, d_run = 1'b0, d_lap = 1'b0;
  logic [SW-1:0] d_thr = '0;

  logic [SW-1:0] el_w, el_s, lv_w, lv_s;
  logic [5:0]    sec_w, sec_s;
  logic [1:0]    min_w, min_s;
  logic          tk_w, tk_s, lpv_w, lpv_s, hit_w, hit_s, ov_w, ov_s;

  elapsed_time_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SEC_WIDTH(SW), .SATURATE(0)) u_wrap (
    .i_clk(clk), .i_reset(d_reset), .i_clear(d_clear), .i_run(d_run), .i_lap(d_lap),
    .i_threshold(d_thr), .o_elapsed(el_w), .o_seconds(sec_w), .o_minutes(min_w), .o_tick(tk_w),
    .o_lap_value(lv_w), .o_lap_valid(lpv_w), .o_thresh_hit(hit_w), .o_overflow(ov_w));

  elapsed_time_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SEC_WIDTH(SW), .SATURATE(1)) u_sat (
    .i_clk(clk), .i_reset(d_reset), .i_clear(d_clear), .i_run(d_run), .i_lap(d_lap),
    .i_threshold(d_thr), .o_elapsed(el_s), .o_seconds(sec_s), .o_minutes(min_s), .o_tick(tk_s),
    .o_lap_value(lv_s), .o_lap_valid(lpv_s), .o_thresh_hit(hit_s), .o_overflow(ov_s));

  always @(negedge clk) begin
    assert (int'(min_w) * 60 + int'(sec_w) == int'(el_w) && sec_w < 60)
      else $error("FAIL invariant_wrap min=%0d sec=%0d elapsed=%0d", min_w, sec_w, el_w);
    assert (int'(min_s) * 60 + int'(sec_s) == int'(el_s) && sec_s < 60)
      else $error("FAIL invariant_sat min=%0d sec=%0d elapsed=%0d", min_s, sec_s, el_s);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: everything follows from the number of running cycles since the last reset/clear.
  int run_cnt = 0;
  int m_ew = 0, m_es = 0, m_lw = 0, m_ls = 0, m_lv = 0;
  int m_tw = 0, m_ts = 0, m_hw = 0, m_hs = 0, m_ow = 0, m_os = 0;

  task automatic model_update(input bit rs, input bit c, input bit r, input bit l, input int thr);
    int pw, ps, ticks;
    pw = m_ew; ps = m_es;
    m_tw = 0; m_ts = 0; m_hw = 0; m_hs = 0; m_lv = 0;
    if (rs || c) begin
      run_cnt = 0;
      m_ew = 0; m_es = 0; m_lw = 0; m_ls = 0; m_ow = 0; m_os = 0;
    end else begin
      if (l) begin
        m_lw = pw; m_ls = ps; m_lv = 1;
      end
      if (r) begin
        run_cnt++;
        if (run_cnt % DIV == 0) begin
          ticks = run_cnt / DIV;
          m_ew = ticks % MAXP1;
          m_tw = 1;
          m_hw = int'(thr != 0 && m_ew == thr);
          if (ticks >= MAXP1) m_ow = 1;
          if (ticks < MAXP1) begin
            m_es = ticks; m_ts = 1;
            m_hs = int'(thr != 0 && ticks == thr);
          end else begin
            m_os = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    check("wrap_elapsed", int'(el_w), m_ew);
    check("wrap_seconds", int'(sec_w), m_ew % 60);
    check("wrap_minutes", int'(min_w), m_ew / 60);
    check("wrap_tick", int'(tk_w), m_tw);
    check("wrap_lap_value", int'(lv_w), m_lw);
    check("wrap_lap_valid", int'(lpv_w), m_lv);
    check("wrap_thresh_hit", int'(hit_w), m_hw);
    check("wrap_overflow", int'(ov_w), m_ow);
    check("sat_elapsed", int'(el_s), m_es);
    check("sat_seconds", int'(sec_s), m_es % 60);
    check("sat_minutes", int'(min_s), m_es / 60);
    check("sat_tick", int'(tk_s), m_ts);
    check("sat_lap_value", int'(lv_s), m_ls);
    check("sat_lap_valid", int'(lpv_s), m_lv);
    check("sat_thresh_hit", int'(hit_s), m_hs);
    check("sat_overflow", int'(ov_s), m_os);
  endtask

  task automatic step(input bit rs, input bit c, input bit r, input bit l, input int thr);
    d_reset = rs; d_clear = c; d_run = r; d_lap = l; d_thr = thr[SW-1:0];
    @(posedge clk);
    model_update(rs, c, r, l, thr);
    #1;
    compare_model();
  endtask

  typedef struct {
    int n; bit run; bit clr; int e; int s; int m; int tk;
  } vec_t;
  vec_t tbl[10];

  int hits;
  int thr_r;

  initial begin
    tbl[0] = '{9,   1'b1, 1'b0, 0,  0, 0, 0};
    tbl[1] = '{1,   1'b1, 1'b0, 1,  1, 0, 1};
    tbl[2] = '{1,   1'b1, 1'b0, 1,  1, 0, 0};
    tbl[3] = '{639, 1'b1, 1'b0, 65, 5, 1, 1};
    tbl[4] = '{5,   1'b0, 1'b0, 65, 5, 1, 0};
    tbl[5] = '{1,   1'b1, 1'b1, 0,  0, 0, 0};
    tbl[6] = '{34,  1'b1, 1'b0, 3,  3, 0, 0};
    tbl[7] = '{50,  1'b0, 1'b0, 3,  3, 0, 0};
    tbl[8] = '{5,   1'b1, 1'b0, 3,  3, 0, 0};
    tbl[9] = '{1,   1'b1, 1'b0, 4,  4, 0, 1};

    step(1, 0, 0, 0, 0);
    check("reset_elapsed", int'(el_w), 0);
    check("reset_overflow", int'(ov_s), 0);

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(0, tbl[i].clr, tbl[i].run, 0, 0);
      check($sformatf("vec%0d_elapsed", i), int'(el_w), tbl[i].e);
      check($sformatf("vec%0d_seconds", i), int'(sec_w), tbl[i].s);
      check($sformatf("vec%0d_minutes", i), int'(min_w), tbl[i].m);
      check($sformatf("vec%0d_tick", i), int'(tk_w), tbl[i].tk);
    end

    // Overflow: wrap vs saturate at 127 -> next tick.
    step(0, 1, 0, 0, 0);
    repeat (1270) step(0, 0, 1, 0, 0);
    check("pre_ovf_wrap", int'(el_w), 127);
    check("pre_ovf_sat", int'(el_s), 127);
    repeat (10) step(0, 0, 1, 0, 0);
    check("ovf_wrap_elapsed", int'(el_w), 0);
    check("ovf_wrap_min", int'(min_w), 0);
    check("ovf_wrap_tick", int'(tk_w), 1);
    check("ovf_wrap_flag", int'(ov_w), 1);
    check("ovf_sat_elapsed", int'(el_s), 127);
    check("ovf_sat_tick", int'(tk_s), 0);
    check("ovf_sat_flag", int'(ov_s), 1);
    repeat (10) step(0, 0, 1, 0, 0);
    check("post_ovf_wrap", int'(el_w), 1);
    check("post_ovf_wrap_sticky", int'(ov_w), 1);

    // Threshold pulses.
    step(0, 1, 0, 0, 5);
    hits = 0;
    for (int k = 0; k < 60; k++) begin step(0, 0, 1, 0, 5); hits += int'(hit_w); end
    check("thr5_hits", hits, 1);
    step(0, 1, 0, 0, 5);
    hits = 0;
    for (int k = 0; k < 60; k++) begin step(0, 0, 1, 0, 5); hits += int'(hit_w); end
    check("thr5_rerun_hits", hits, 1);
    hits = 0;
    for (int k = 0; k < 5; k++) begin step(0, 0, 0, 0, 6); hits += int'(hit_w); end
    check("thr_onto_current", hits, 0);
    step(0, 1, 0, 0, 0);
    hits = 0;
    for (int k = 0; k < 60; k++) begin step(0, 0, 1, 0, 0); hits += int'(hit_w); end
    check("thr0_hits", hits, 0);

    // Lap coinciding with the 8->9 tick, then lap with clear.
    step(0, 1, 0, 0, 0);
    repeat (89) step(0, 0, 1, 0, 0);
    check("lap_pre_elapsed", int'(el_w), 8);
    step(0, 0, 1, 1, 0);
    check("lap_value", int'(lv_w), 8);
    check("lap_valid", int'(lpv_w), 1);
    check("lap_elapsed", int'(el_w), 9);
    step(0, 0, 0, 0, 0);
    check("lap_valid_drop", int'(lpv_w), 0);
    step(0, 1, 0, 1, 0);
    check("lap_clear_valid", int'(lpv_w), 0);
    check("lap_clear_value", int'(lv_w), 0);

    // Reset, then clear, mid-count at prescaler 7 / elapsed 20.
    for (int pass = 0; pass < 2; pass++) begin
      step(0, 1, 0, 0, 0);
      repeat (207) step(0, 0, 1, 0, 0);
      check("mid_elapsed", int'(el_w), 20);
      step(pass == 0, pass == 1, 1, 1, 0);
      check("mid_zero_elapsed", int'(el_w), 0);
      check("mid_zero_lap", int'(lpv_w), 0);
      repeat (9) step(0, 0, 1, 0, 0);
      check("mid_restart_9", int'(el_w), 0);
      step(0, 0, 1, 0, 0);
      check("mid_restart_10", int'(el_w), 1);
    end

    // Randomized traffic against the model.
    step(1, 0, 0, 0, 0);
    thr_r = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) thr_r = $urandom_range(0, 127);
      if ($urandom_range(0, 299) == 0) thr_r = m_ew;
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 2999) == 0,
           $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, thr_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
